// File: rtl/adder_axi_pkg.sv
// Shared definitions for the adder AXI4-Lite master: register map of the
// adder slave, response encoding and the sequencing state type.
package adder_axi_pkg;

    localparam int ADDR_OP_A     = 0;
    localparam int ADDR_OP_B     = 4;
    localparam int ADDR_RESULT   = 8;
    localparam int ADDR_OVERFLOW = 12;

    localparam logic RESP_OKAY = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        RD_RES,
        RD_OVF,
        FIN
    } state_t;

    // True for the states that own an outstanding bus transaction.
    function automatic logic is_xfer_state(input state_t s);
        return (s == WR_A) || (s == WR_B) || (s == RD_RES) || (s == RD_OVF);
    endfunction

endpackage

// File: rtl/adder_axi_master_if.sv
// AXI4-Lite signal bundle between the adder master and the adder slave.
// The response fields are single bits where 1 means OKAY.
interface adder_axi_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);

    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/adder_axi_tmo.sv
// Per-transaction stall counter. Cleared whenever the master changes state,
// counts while a transaction is in flight and flags expiry on the cycle
// whose closing edge is the TIMEOUT_CYCLES-th edge since state entry.
module adder_axi_tmo #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Count stall cycles; saturate once expired so the flag stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/adder_axi_master.sv
// AXI4-Lite master that runs the fixed adder sequence: write A, write B,
// read the sum, read the overflow flag, then report back to the controller.
// Every output is registered: the combinational block computes next values
// for the whole output set and a single register stage holds them.
module adder_axi_master
    import adder_axi_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  m1_axi_aclk,
    input  logic                  m1_axi_aresetn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  err_resp,
    output logic                  err_timeout,
    adder_axi_master_if.master    m1_axi
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_t state_q, state_nxt;

    logic                  busy_q, busy_nxt;
    logic                  done_q, done_nxt;
    logic [DATA_WIDTH-1:0] result_q, result_nxt;
    logic                  overflow_q, overflow_nxt;
    logic                  err_resp_q, err_resp_nxt;
    logic                  err_tmo_q, err_tmo_nxt;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_nxt;

    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_nxt;
    logic                  awvalid_q, awvalid_nxt;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
    logic [STRB_W-1:0]     wstrb_q, wstrb_nxt;
    logic                  wvalid_q, wvalid_nxt;
    logic                  bready_q, bready_nxt;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_nxt;
    logic                  arvalid_q, arvalid_nxt;
    logic                  rready_q, rready_nxt;

    logic tmo_clear;
    logic tmo_expired;

    assign tmo_clear = (state_nxt != state_q);

    adder_axi_tmo #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (m1_axi_aclk),
        .rst_n  (m1_axi_aresetn),
        .clear  (tmo_clear),
        .enable (is_xfer_state(state_q)),
        .expired(tmo_expired)
    );

    // Sequencer: next state plus next value of every registered output.
    always_comb begin
        state_nxt    = state_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        result_nxt   = result_q;
        overflow_nxt = overflow_q;
        err_resp_nxt = err_resp_q;
        err_tmo_nxt  = err_tmo_q;
        op_b_nxt     = op_b_q;
        awaddr_nxt   = awaddr_q;
        awvalid_nxt  = awvalid_q;
        wdata_nxt    = wdata_q;
        wvalid_nxt   = wvalid_q;
        bready_nxt   = bready_q;
        araddr_nxt   = araddr_q;
        arvalid_nxt  = arvalid_q;
        rready_nxt   = rready_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_nxt    = WR_A;
                    busy_nxt     = 1'b1;
                    result_nxt   = '0;
                    overflow_nxt = 1'b0;
                    err_resp_nxt = 1'b0;
                    err_tmo_nxt  = 1'b0;
                    op_b_nxt     = op_b;
                    awaddr_nxt   = ADDR_WIDTH'(ADDR_OP_A);
                    wdata_nxt    = op_a;
                    awvalid_nxt  = 1'b1;
                    wvalid_nxt   = 1'b1;
                    bready_nxt   = 1'b1;
                end
            end

            WR_A, WR_B: begin
                if (awvalid_q && m1_axi.awready) begin
                    awvalid_nxt = 1'b0;
                end
                if (wvalid_q && m1_axi.wready) begin
                    wvalid_nxt = 1'b0;
                end
                if (bready_q && m1_axi.bvalid) begin
                    awvalid_nxt = 1'b0;
                    wvalid_nxt  = 1'b0;
                    bready_nxt  = 1'b0;
                    if (m1_axi.bresp != RESP_OKAY) begin
                        err_resp_nxt = 1'b1;
                    end
                    if (state_q == WR_A) begin
                        state_nxt   = WR_B;
                        awaddr_nxt  = ADDR_WIDTH'(ADDR_OP_B);
                        wdata_nxt   = op_b_q;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        bready_nxt  = 1'b1;
                    end else begin
                        state_nxt   = RD_RES;
                        araddr_nxt  = ADDR_WIDTH'(ADDR_RESULT);
                        arvalid_nxt = 1'b1;
                        rready_nxt  = 1'b1;
                    end
                end else if (tmo_expired) begin
                    state_nxt   = FIN;
                    err_tmo_nxt = 1'b1;
                    awvalid_nxt = 1'b0;
                    wvalid_nxt  = 1'b0;
                    bready_nxt  = 1'b0;
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b0;
                end
            end

            RD_RES, RD_OVF: begin
                if (arvalid_q && m1_axi.arready) begin
                    arvalid_nxt = 1'b0;
                end
                if (rready_q && m1_axi.rvalid) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b0;
                    if (m1_axi.rresp != RESP_OKAY) begin
                        err_resp_nxt = 1'b1;
                    end
                    if (state_q == RD_RES) begin
                        result_nxt  = m1_axi.rdata;
                        state_nxt   = RD_OVF;
                        araddr_nxt  = ADDR_WIDTH'(ADDR_OVERFLOW);
                        arvalid_nxt = 1'b1;
                        rready_nxt  = 1'b1;
                    end else begin
                        overflow_nxt = m1_axi.rdata[0];
                        state_nxt    = FIN;
                    end
                end else if (tmo_expired) begin
                    state_nxt   = FIN;
                    err_tmo_nxt = 1'b1;
                    awvalid_nxt = 1'b0;
                    wvalid_nxt  = 1'b0;
                    bready_nxt  = 1'b0;
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b0;
                end
            end

            FIN: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // done is high for exactly the FIN cycle and busy drops with it.
        if ((state_nxt == FIN) && (state_q != FIN)) begin
            done_nxt = 1'b1;
            busy_nxt = 1'b0;
        end

        wstrb_nxt = wvalid_nxt ? '1 : '0;
    end

    // Single register stage for state and all outputs; reset clears the bus.
    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            err_resp_q <= 1'b0;
            err_tmo_q  <= 1'b0;
            op_b_q     <= '0;
            awaddr_q   <= '0;
            awvalid_q  <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            result_q   <= result_nxt;
            overflow_q <= overflow_nxt;
            err_resp_q <= err_resp_nxt;
            err_tmo_q  <= err_tmo_nxt;
            op_b_q     <= op_b_nxt;
            awaddr_q   <= awaddr_nxt;
            awvalid_q  <= awvalid_nxt;
            wdata_q    <= wdata_nxt;
            wstrb_q    <= wstrb_nxt;
            wvalid_q   <= wvalid_nxt;
            bready_q   <= bready_nxt;
            araddr_q   <= araddr_nxt;
            arvalid_q  <= arvalid_nxt;
            rready_q   <= rready_nxt;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign overflow    = overflow_q;
    assign err_resp    = err_resp_q;
    assign err_timeout = err_tmo_q;

    assign m1_axi.awaddr  = awaddr_q;
    assign m1_axi.awvalid = awvalid_q;
    assign m1_axi.wdata   = wdata_q;
    assign m1_axi.wstrb   = wstrb_q;
    assign m1_axi.wvalid  = wvalid_q;
    assign m1_axi.bready  = bready_q;
    assign m1_axi.araddr  = araddr_q;
    assign m1_axi.arvalid = arvalid_q;
    assign m1_axi.rready  = rready_q;

endmodule

// File: tb/tb_adder_axi_master.sv
// Bench for adder_axi_master: a behavioural adder slave answers the bus,
// expected completions are queued when a start is issued and compared when
// done pulses.
module tb_adder_axi_master;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int TMO = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] op_a  = '0;
    logic [DW-1:0] op_b  = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] result;
    logic          overflow;
    logic          err_resp;
    logic          err_timeout;

    adder_axi_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_axi ();

    adder_axi_master #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .m1_axi_aclk   (clk),
        .m1_axi_aresetn(rst_n),
        .start         (start),
        .op_a          (op_a),
        .op_b          (op_b),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .overflow      (overflow),
        .err_resp      (err_resp),
        .err_timeout   (err_timeout),
        .m1_axi        (m1_axi)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] result;
        logic          overflow;
        logic          err_resp;
        logic          err_timeout;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [AW-1:0] addr_log[$];
    logic [AW-1:0] exp_addr[4];
    int            n_checks    = 0;
    int            n_fail      = 0;
    int            done_count  = 0;
    int            cycle       = 0;
    int            start_cycle = 0;
    int            base;
    int            lat;
    bit            seen;
    bit            stub_no_awready = 1'b0;
    bit            stub_bad_b4     = 1'b0;
    logic [DW-1:0] slv_a, slv_b;
    logic [DW:0]   slv_sum;

    assign slv_sum = {1'b0, slv_a} + {1'b0, slv_b};

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Cycle counter used for latency measurement.
    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural adder slave with one wait state per channel.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_axi.awready <= 1'b0;
            m1_axi.wready  <= 1'b0;
            m1_axi.bvalid  <= 1'b0;
            m1_axi.bresp   <= 1'b0;
            m1_axi.arready <= 1'b0;
            m1_axi.rvalid  <= 1'b0;
            m1_axi.rdata   <= '0;
            m1_axi.rresp   <= 1'b0;
            slv_a          <= '0;
            slv_b          <= '0;
        end else begin
            m1_axi.awready <= 1'b0;
            m1_axi.wready  <= 1'b0;
            m1_axi.arready <= 1'b0;
            if (m1_axi.bvalid && m1_axi.bready) m1_axi.bvalid <= 1'b0;
            if (m1_axi.rvalid && m1_axi.rready) m1_axi.rvalid <= 1'b0;
            if (!stub_no_awready && m1_axi.awvalid && m1_axi.wvalid && m1_axi.bready &&
                !m1_axi.awready && !m1_axi.bvalid) begin
                m1_axi.awready <= 1'b1;
                m1_axi.wready  <= 1'b1;
            end
            if (m1_axi.awready && m1_axi.awvalid) begin
                addr_log.push_back(m1_axi.awaddr);
                checkOutput("wstrb", 64'(m1_axi.wstrb), 64'(4'hF));
                if (m1_axi.awaddr == 8'd0) slv_a <= m1_axi.wdata;
                if (m1_axi.awaddr == 8'd4) slv_b <= m1_axi.wdata;
                m1_axi.bvalid <= 1'b1;
                m1_axi.bresp  <= (stub_bad_b4 && m1_axi.awaddr == 8'd4) ? 1'b0 : 1'b1;
            end
            if (m1_axi.arvalid && !m1_axi.arready && !m1_axi.rvalid) m1_axi.arready <= 1'b1;
            if (m1_axi.arready && m1_axi.arvalid) begin
                addr_log.push_back(m1_axi.araddr);
                m1_axi.rvalid <= 1'b1;
                m1_axi.rresp  <= 1'b1;
                if (m1_axi.araddr == 8'd8)       m1_axi.rdata <= slv_sum[DW-1:0];
                else if (m1_axi.araddr == 8'd12) m1_axi.rdata <= {{(DW-1){1'b0}}, slv_sum[DW]};
                else                             m1_axi.rdata <= '0;
            end
        end
    end

    // Scoreboard: every done pulse retires the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 64'(1), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("result", 64'(result), 64'(mon_e.result));
                checkOutput("overflow", 64'(overflow), 64'(mon_e.overflow));
                checkOutput("err_resp", 64'(err_resp), 64'(mon_e.err_resp));
                checkOutput("err_timeout", 64'(err_timeout), 64'(mon_e.err_timeout));
                checkOutput("busy_at_done", 64'(busy), 64'(0));
            end
        end
    end

    task automatic pulseStart(input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        start_cycle = cycle;
        op_a        = ~a;
        op_b        = ~b;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic er, input logic et);
        exp_t        e;
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        e.result      = et ? '0 : s[DW-1:0];
        e.overflow    = et ? 1'b0 : s[DW];
        e.err_resp    = er;
        e.err_timeout = et;
        exp_q.push_back(e);
        pulseStart(a, b);
    endtask

    task automatic waitDone(input int max_cycles, output int latency, output bit got);
        got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        latency = cycle - start_cycle;
        if (!got) checkOutput("done_wait_expired", 64'(0), 64'(1));
    endtask

    task automatic waitBus(input bit is_read, input logic [AW-1:0] addr);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge clk);
            if (is_read) hit = m1_axi.arvalid && (m1_axi.araddr == addr);
            else         hit = m1_axi.awvalid && (m1_axi.awaddr == addr);
        end
        if (!hit) checkOutput("bus_wait_expired", 64'(0), 64'(1));
    endtask

    // Hard stop in case the main sequence wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        exp_addr = '{8'd0, 8'd4, 8'd8, 8'd12};
        repeat (3) @(negedge clk);

        // Reset state.
        checkOutput("rst_busy", 64'(busy), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_result", 64'(result), 64'(0));
        checkOutput("rst_overflow", 64'(overflow), 64'(0));
        checkOutput("rst_err_resp", 64'(err_resp), 64'(0));
        checkOutput("rst_err_timeout", 64'(err_timeout), 64'(0));
        checkOutput("rst_valids", 64'({m1_axi.awvalid, m1_axi.wvalid, m1_axi.bready,
                                       m1_axi.arvalid, m1_axi.rready}), 64'(0));
        checkOutput("rst_awaddr", 64'(m1_axi.awaddr), 64'(0));
        checkOutput("rst_araddr", 64'(m1_axi.araddr), 64'(0));
        checkOutput("rst_wdata", 64'(m1_axi.wdata), 64'(0));
        checkOutput("rst_wstrb", 64'(m1_axi.wstrb), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 5 + 7 with the address order on the bus.
        $display("[TB] basic add");
        addr_log.delete();
        base = done_count;
        applyStimulus(32'd5, 32'd7, 1'b0, 1'b0);
        checkOutput("busy_after_start", 64'(busy), 64'(1));
        checkOutput("launch_valids", 64'({m1_axi.awvalid, m1_axi.wvalid, m1_axi.bready}), 64'(3'b111));
        waitDone(64, lat, seen);
        repeat (3) @(negedge clk);
        checkOutput("basic_done_count", 64'(done_count - base), 64'(1));
        checkOutput("addr_count", 64'(addr_log.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < addr_log.size()) checkOutput("addr_order", 64'(addr_log[i]), 64'(exp_addr[i]));
        end

        // Carry out of the top bit.
        $display("[TB] overflow add");
        applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        waitDone(64, lat, seen);
        repeat (2) @(negedge clk);

        // Error response on the operand B write.
        $display("[TB] bad write response");
        stub_bad_b4 = 1'b1;
        applyStimulus(32'd10, 32'd20, 1'b1, 1'b0);
        waitDone(64, lat, seen);
        stub_bad_b4 = 1'b0;
        repeat (2) @(negedge clk);

        // Start while busy is ignored.
        $display("[TB] start while busy");
        base = done_count;
        applyStimulus(32'd100, 32'd23, 1'b0, 1'b0);
        waitBus(1'b1, 8'd8);
        checkOutput("busy_in_rd_res", 64'(busy), 64'(1));
        pulseStart(32'd9, 32'd9);
        waitDone(64, lat, seen);
        repeat (20) @(negedge clk);
        checkOutput("ignored_done_count", 64'(done_count - base), 64'(1));
        checkOutput("result_held", 64'(result), 64'(123));

        // Slave never accepts the write address: timeout abort.
        $display("[TB] timeout");
        stub_no_awready = 1'b1;
        applyStimulus(32'd1, 32'd2, 1'b0, 1'b1);
        waitDone(64, lat, seen);
        checkOutput("timeout_latency", 64'(lat), 64'(TMO));
        checkOutput("timeout_bus_idle", 64'({m1_axi.awvalid, m1_axi.wvalid, m1_axi.bready}), 64'(0));
        stub_no_awready = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in WR_B, then a clean run.
        $display("[TB] reset mid sequence");
        applyStimulus(32'd11, 32'd22, 1'b0, 1'b0);
        waitBus(1'b0, 8'd4);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valids", 64'({m1_axi.awvalid, m1_axi.wvalid, m1_axi.bready}), 64'(0));
        checkOutput("async_rst_busy", 64'(busy), 64'(0));
        exp_q.delete();
        base = done_count;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("no_done_after_rst", 64'(done_count - base), 64'(0));
        applyStimulus(32'd3, 32'd4, 1'b0, 1'b0);
        waitDone(64, lat, seen);
        repeat (3) @(negedge clk);
        checkOutput("post_rst_done_count", 64'(done_count - base), 64'(1));
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
